// File: rtl/spoly_seq.sv
// ---------------------------------------------------------------------------
// spoly_seq : sequencer for the SNTRUP757 small-polynomial generator.
//
// One start request produces an f/g pair. The generator is run into bank 0
// (f), the written coefficients are read back and their Hamming weight is
// compared with W. A wrong weight regenerates f, for up to MAX_TRY attempts.
// When f is accepted the generator is run once more into bank 1 (g).
//
// Optional feature, macro SPOLY_TIMEOUT_EN: a watchdog aborts a generator
// run that shows no completion edge within TIMEOUT cycles of gen_start.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   1-cycle request for an f/g pair, ignored unless idle
//   gen_start  out  1-cycle start pulse to the generator
//   gen_done   in   generator completion level (its write_done)
//   bank_sel   out  0 = generator writes bank f, 1 = bank g
//   rd_en      out  checker read strobe
//   rd_addr    out  checker read address
//   rd_data    in   read data, valid 1 cycle after rd_en
//   rd_owner   out  1 = checker owns the memory read port
//   busy       out  high from accepted start until done or fail
//   done       out  1-cycle pulse: pair generated, bank-0 weight correct
//   fail       out  1-cycle pulse: attempts exhausted or watchdog expired
//   attempts   out  bank-0 attempts in the current or last run
// ---------------------------------------------------------------------------
module spoly_seq #(
   parameter int unsigned P       = 757,
   parameter int unsigned W       = 286,
   parameter int unsigned MAX_TRY = 8,
   parameter int unsigned AW      = 11,
   parameter int unsigned DW      = 13
`ifdef SPOLY_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT = 4095
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          gen_start,
   input  logic          gen_done,
   output logic          bank_sel,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic          rd_owner,
   output logic          busy,
   output logic          done,
   output logic          fail,
   output logic [3:0]    attempts
);

   localparam int unsigned IW  = $clog2(P + 2);
   localparam int unsigned CW  = 10;
   localparam int unsigned TW  = 4;
`ifdef SPOLY_TIMEOUT_EN
   localparam int unsigned WDW = 12;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_GEN_F,
      S_CHK,
      S_EVAL,
      S_GEN_G,
      S_DONE,
      S_FAIL
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic          r_gd_q1;
   logic          r_gd_q2;
   logic          w_gd_edge;
   logic          w_gen_wait;
   logic          w_gen_fin;
   logic          w_wd_expired;

   logic [IW-1:0] r_idx;
   logic [IW-1:0] w_idx_nxt;
   logic          r_rd_vld;
   logic [CW-1:0] r_wcnt;
   logic [TW-1:0] r_attempts;
   logic [TW-1:0] w_attempts_nxt;

   logic          r_gen_start, w_gen_start_nxt;
   logic          r_bank_sel,  w_bank_sel_nxt;
   logic          r_rd_en,     w_rd_en_nxt;
   logic [AW-1:0] r_rd_addr,   w_rd_addr_nxt;
   logic          r_rd_owner,  w_rd_owner_nxt;
   logic          r_busy,      w_busy_nxt;
   logic          r_done,      w_done_nxt;
   logic          r_fail,      w_fail_nxt;

`ifdef SPOLY_TIMEOUT_EN
   logic [WDW-1:0] r_wd;
`endif

   // Completion is a 0->1 edge of the registered gen_done level
   assign w_gd_edge = r_gd_q1 & ~r_gd_q2;

   // Edges are only accepted after the gen_start cycle, so a stale level or
   // an edge racing the start pulse can never complete the new run
   assign w_gen_wait = ((r_state == S_GEN_F) || (r_state == S_GEN_G)) && !r_gen_start;
   assign w_gen_fin  = w_gen_wait && w_gd_edge;

`ifdef SPOLY_TIMEOUT_EN
   assign w_wd_expired = (r_wd == WDW'(TIMEOUT - 1));
`else
   assign w_wd_expired = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      w_state_nxt    = r_state;
      w_attempts_nxt = r_attempts;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt    = S_GEN_F;
               w_attempts_nxt = TW'(1);
            end
         end
         S_GEN_F: begin
            if (w_gen_fin)         w_state_nxt = S_CHK;
            else if (w_wd_expired) w_state_nxt = S_FAIL;
         end
         S_CHK: begin
            // idx P is the drain cycle for the last read
            if (r_idx == IW'(P)) w_state_nxt = S_EVAL;
         end
         S_EVAL: begin
            if (r_wcnt == CW'(W)) begin
               w_state_nxt = S_GEN_G;
            end else if (r_attempts == TW'(MAX_TRY)) begin
               w_state_nxt = S_FAIL;
            end else begin
               w_state_nxt    = S_GEN_F;
               w_attempts_nxt = r_attempts + TW'(1);
            end
         end
         S_GEN_G: begin
            if (w_gen_fin)         w_state_nxt = S_DONE;
            else if (w_wd_expired) w_state_nxt = S_FAIL;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         S_FAIL:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output next values, derived from the upcoming state so every output is a flop
   always_comb begin
      w_idx_nxt       = (r_state == S_CHK) ? (r_idx + IW'(1)) : '0;
      w_gen_start_nxt = ((w_state_nxt == S_GEN_F) || (w_state_nxt == S_GEN_G)) &&
                        (w_state_nxt != r_state);
      w_bank_sel_nxt  = (w_state_nxt == S_GEN_G);
      w_rd_owner_nxt  = (w_state_nxt == S_CHK);
      w_rd_en_nxt     = (w_state_nxt == S_CHK) && (w_idx_nxt < IW'(P));
      w_rd_addr_nxt   = w_rd_en_nxt ? AW'(w_idx_nxt) : '0;
      w_busy_nxt      = (w_state_nxt == S_GEN_F) || (w_state_nxt == S_CHK) ||
                        (w_state_nxt == S_EVAL)  || (w_state_nxt == S_GEN_G);
      w_done_nxt      = (w_state_nxt == S_DONE);
      w_fail_nxt      = (w_state_nxt == S_FAIL);
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_attempts  <= '0;
         r_idx       <= '0;
         r_gen_start <= 1'b0;
         r_bank_sel  <= 1'b0;
         r_rd_en     <= 1'b0;
         r_rd_addr   <= '0;
         r_rd_owner  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_fail      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_attempts  <= w_attempts_nxt;
         r_idx       <= w_idx_nxt;
         r_gen_start <= w_gen_start_nxt;
         r_bank_sel  <= w_bank_sel_nxt;
         r_rd_en     <= w_rd_en_nxt;
         r_rd_addr   <= w_rd_addr_nxt;
         r_rd_owner  <= w_rd_owner_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_fail      <= w_fail_nxt;
      end
   end

   // gen_done registration for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gd_q1 <= 1'b0;
         r_gd_q2 <= 1'b0;
      end else begin
         r_gd_q1 <= gen_done;
         r_gd_q2 <= r_gd_q1;
      end
   end

   // Weight counter: read data arrives the cycle after the strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_vld <= 1'b0;
         r_wcnt   <= '0;
      end else begin
         r_rd_vld <= r_rd_en;
         if (r_state == S_GEN_F) begin
            r_wcnt <= '0;
         end else if (r_rd_vld && (rd_data != '0) && (r_wcnt != '1)) begin
            r_wcnt <= r_wcnt + CW'(1);
         end
      end
   end

`ifdef SPOLY_TIMEOUT_EN
   // Watchdog restarts with every gen_start and runs while a generator run is pending
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wd <= '0;
      end else if (w_gen_start_nxt) begin
         r_wd <= '0;
      end else if ((r_state == S_GEN_F) || (r_state == S_GEN_G)) begin
         r_wd <= r_wd + WDW'(1);
      end
   end
`endif

   assign gen_start = r_gen_start;
   assign bank_sel  = r_bank_sel;
   assign rd_en     = r_rd_en;
   assign rd_addr   = r_rd_addr;
   assign rd_owner  = r_rd_owner;
   assign busy      = r_busy;
   assign done      = r_done;
   assign fail      = r_fail;
   assign attempts  = r_attempts;

endmodule

// File: tb/tb_spoly_seq.sv
// ---------------------------------------------------------------------------
// tb_spoly_seq : scoreboard bench for spoly_seq.
// A generator/memory model fills the banks with a chosen nonzero count; each
// directed run pushes its expected end-of-run record, and a monitor pops and
// compares it when the DUT pulses done or fail.
// ---------------------------------------------------------------------------
module tb_spoly_seq;

   localparam int unsigned P       = 757;
   localparam int unsigned AW      = 11;
   localparam int unsigned DW      = 13;
   localparam int unsigned TIMEOUT = 4095;
   localparam int unsigned TGEN    = 20;
   localparam int unsigned TSTALE  = 50;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          gen_start;
   logic          gen_done;
   logic          bank_sel;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_owner;
   logic          busy;
   logic          done;
   logic          fail;
   logic [3:0]    attempts;

   spoly_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .gen_start(gen_start),
      .gen_done (gen_done),
      .bank_sel (bank_sel),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_owner (rd_owner),
      .busy     (busy),
      .done     (done),
      .fail     (fail),
      .attempts (attempts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit is_done;
      int att;
      int nf;
      int ng;
      int chk;
      int rden;
      bit stale;
      bit tmo;
   } want_t;

   want_t want_q[$];

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // generator / memory model state
   logic [DW-1:0] mem0 [0:P-1];
   logic [DW-1:0] mem1 [0:P-1];
   int  fill_q[$];
   int  fill_default = 286;
   bit  stale_mode   = 1'b0;
   bit  never_done   = 1'b0;
   bit  gen_active   = 1'b0;
   bit  gen_bank     = 1'b0;
   int  rise_f_cyc   = 0;

   task automatic check(input string name, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   task automatic push_want(input bit d, input int att, input int nf, input int ng,
                            input bit stale, input bit tmo);
      want_t w;
      w.is_done = d;
      w.att     = att;
      w.nf      = nf;
      w.ng      = ng;
      w.chk     = nf * int'(P + 1);
      w.rden    = nf * int'(P);
      w.stale   = stale;
      w.tmo     = tmo;
      want_q.push_back(w);
   endtask

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Generator model: fills a bank on gen_start, then raises gen_done
   initial begin
      int n;
      gen_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && gen_start) begin
            gen_bank   = bank_sel;
            gen_active = 1'b1;
            if (!gen_bank && fill_q.size() > 0) n = fill_q.pop_front();
            else                                n = fill_default;
            for (int i = 0; i < int'(P); i++) begin
               logic [DW-1:0] v;
               v = ((i % 2 == 0) && (i < 2 * n)) ? DW'(i + 1) : '0;
               if (gen_bank) mem1[i] = v;
               else          mem0[i] = v;
            end
            if (stale_mode) repeat (3) @(negedge clk);
            gen_done = 1'b0;
            if (!never_done) begin
               repeat (stale_mode ? TSTALE : TGEN) @(negedge clk);
               gen_done = 1'b1;
               if (!gen_bank) rise_f_cyc = cyc;
            end
            gen_active = 1'b0;
         end
      end
   end

   // Bank-0 read port: data for the strobe of one cycle appears the next cycle
   initial begin
      bit            pend_en;
      logic [AW-1:0] pend_addr;
      pend_en   = 1'b0;
      pend_addr = '0;
      rd_data   = '0;
      forever begin
         @(negedge clk);
         rd_data   = (pend_en && pend_addr < AW'(P)) ? mem0[pend_addr] : '0;
         pend_en   = rd_en;
         pend_addr = rd_addr;
      end
   end

   // Monitor: gathers per-run statistics and scores each done/fail pulse
   initial begin
      int nf, ng, chk_cyc, rden_cnt, glitch, first_chk, gs_cyc;
      want_t w;
      nf = 0; ng = 0; chk_cyc = 0; rden_cnt = 0; glitch = 0; first_chk = -1; gs_cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            nf = 0; ng = 0; chk_cyc = 0; rden_cnt = 0; glitch = 0; first_chk = -1;
         end else begin
            if (gen_start) begin
               if (bank_sel) ng++;
               else          nf++;
               gs_cyc = cyc;
            end
            if (rd_owner) begin
               chk_cyc++;
               if (first_chk < 0) first_chk = cyc;
            end
            if (rd_en) rden_cnt++;
            if (gen_active && !gen_start && (bank_sel != gen_bank)) glitch++;
            if (done || fail) begin
               if (want_q.size() == 0) begin
                  check("unexpected_end_pulse", done ? 1 : 2, 0);
               end else begin
                  w = want_q.pop_front();
                  check("end_kind_done", int'(done), int'(w.is_done));
                  check("end_kind_fail", int'(fail), int'(!w.is_done));
                  check("attempts", int'(attempts), w.att);
                  check("bank0_gen_starts", nf, w.nf);
                  check("bank1_gen_starts", ng, w.ng);
                  check("chk_cycles", chk_cyc, w.chk);
                  check("rd_en_cycles", rden_cnt, w.rden);
                  check("busy_at_end", int'(busy), 0);
                  check("bank_sel_stable", glitch, 0);
                  if (w.stale) check("chk_after_new_edge", int'(first_chk > rise_f_cyc), 1);
                  if (w.tmo)   check("timeout_latency", cyc - gs_cyc, int'(TIMEOUT));
               end
               nf = 0; ng = 0; chk_cyc = 0; rden_cnt = 0; glitch = 0; first_chk = -1;
            end
         end
      end
   end

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, int'(busy), 0);
      repeat (3) @(negedge clk);
   endtask

   function automatic int out_vec();
      return int'({gen_start, bank_sel, rd_en, rd_addr, rd_owner, busy, done, fail, attempts});
   endfunction

   initial begin
      int k;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", out_vec(), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // pass on the first attempt
      fill_q = {286};
      push_want(1'b1, 1, 1, 1, 1'b0, 1'b0);
      do_start();
      check("busy_after_start", int'(busy), 1);
      wait_idle("idle_pass", 3000);
      check("bank_sel_idle", int'(bank_sel), 0);

      // one retry; a start pulse while busy must be ignored
      fill_q = {285, 286};
      push_want(1'b1, 2, 2, 1, 1'b0, 1'b0);
      do_start();
      repeat (100) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("idle_retry", 4000);

      // every bank-0 fill has the wrong weight
      fill_default = 300;
      fill_q = {};
      push_want(1'b0, 8, 8, 0, 1'b0, 1'b0);
      do_start();
      wait_idle("idle_exhaust", 10000);
      check("attempts_held", int'(attempts), 8);

      // gen_done still high from the previous run when gen_start is issued
      fill_default = 286;
      stale_mode   = 1'b1;
      check("stale_level_precondition", int'(gen_done), 1);
      push_want(1'b1, 1, 1, 1, 1'b1, 1'b0);
      do_start();
      wait_idle("idle_stale", 3000);
      stale_mode = 1'b0;

      // reset in the middle of the weight check
      do_start();
      k = 0;
      while (!(rd_en && rd_addr == AW'(400)) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("reach_addr_400", int'(rd_addr), 400);
      #2 rst_n = 1'b0;
      #1 check("async_reset_outputs", out_vec(), 0);
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      push_want(1'b1, 1, 1, 1, 1'b0, 1'b0);
      do_start();
      wait_idle("idle_after_reset", 3000);

      // generator that never completes
      never_done = 1'b1;
`ifdef SPOLY_TIMEOUT_EN
      push_want(1'b0, 1, 1, 0, 1'b0, 1'b1);
      do_start();
      wait_idle("idle_timeout", 6000);
`else
      do_start();
      repeat (5000) @(negedge clk);
      check("busy_held_no_done", int'(busy), 1);
      check("no_chk_without_done", int'(rd_owner), 0);
`endif
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      never_done = 1'b0;
      repeat (2) @(negedge clk);

      check("scoreboard_drained", want_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spoly_seq.md
Name: spoly_seq

Overview:
- Sequencer for the small-polynomial generator in the SNTRUP757 keygen path.
- On one start request it runs the generator twice: first into bank 0 (f), then into bank 1 (g).
- After the bank-0 run it reads the written coefficients back and checks that the Hamming weight equals W. If the weight is wrong it regenerates f, up to MAX_TRY attempts.
- It owns the memory read port during the check and reports done, fail and the attempt count.

Parameters:
- P, 757, polynomial length (coefficients per bank)
- W, 286, required nonzero count for bank 0
- MAX_TRY, 8, maximum bank-0 generation attempts before fail
- AW, 11, coefficient address width
- DW, 13, coefficient data width
- TIMEOUT, 4095, watchdog limit in cycles (used only with SPOLY_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle request to generate an f/g pair; ignored unless idle
- gen_start  out  1  1-cycle start pulse to the generator
- gen_done  in  1  generator completion level (its write_done)
- bank_sel  out  1  0 = generator writes bank f, 1 = bank g
- rd_en  out  1  checker read strobe
- rd_addr  out  AW  checker read address
- rd_data  in  DW  read data, returned 1 cycle after rd_en
- rd_owner  out  1  1 = checker owns the memory read port
- busy  out  1  high from accepted start until done or fail
- done  out  1  1-cycle pulse: pair generated and bank-0 weight correct
- fail  out  1  1-cycle pulse: MAX_TRY exceeded (or watchdog expired)
- attempts  out  4  number of bank-0 attempts in the current or last run

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all outputs 0; attempts = 0; state IDLE; counters cleared. Reset mid-run aborts immediately and no done/fail is issued.
- gen_done edge detect:
  - gen_done is registered; a completion is its 0→1 edge.
  - A level already high when gen_start is issued is ignored.
- States:
  - IDLE: start=1 → GEN_F. Set attempts=1, bank_sel=0, busy=1.
  - GEN_F: gen_start=1 for exactly the first cycle in the state, then wait for a gen_done edge → CHK. Clear weight counter and address.
  - CHK:
    - rd_owner=1, rd_en=1; rd_addr steps 0..P-1, one per cycle.
    - Data captured 1 cycle later. Count +1 when rd_data != 0.
    - After issuing address P-1, rd_en=0 and wait one drain cycle → EVAL.
    - CHK lasts P+1 cycles.
  - EVAL:
    - count == W → GEN_G with bank_sel=1.
    - Else if attempts == MAX_TRY → FAIL.
    - Else increment attempts → GEN_F.
    - rd_owner drops on entry to EVAL.
  - GEN_G: same handshake as GEN_F (1-cycle gen_start, wait for edge); on edge → DONE. No weight check on bank 1.
  - DONE: done=1 for one cycle, busy=0 → IDLE. bank_sel returns to 0; attempts is held.
  - FAIL: fail=1 for one cycle, busy=0 → IDLE.
- Weight counter: 10 bits, saturating at 1023. It cannot overflow for P=757.
- start while busy: ignored, no queuing. start in the same cycle as done/fail: ignored, because the FSM is not yet in IDLE.
- Latency of a single successful attempt: 1 + Tgen_f + (P+1) + 1 + Tgen_g + 1 cycles, where Tgen is start-to-edge time.
- bank_sel is stable for the whole generator run and changes only in EVAL/DONE transitions, never while the generator is active.

Optional Feature:
- Macro: SPOLY_TIMEOUT_EN.
- Defined:
  - A 12-bit watchdog counts cycles in GEN_F/GEN_G and clears on each gen_start.
  - Reaching TIMEOUT without a gen_done edge → FAIL (fail pulse, busy=0).
  - attempts keeps its current value.
- Not defined: no watchdog; GEN_F/GEN_G wait indefinitely for gen_done.

Test Plan:
- Pass first try: generator model writes exactly 286 nonzeros to bank 0. Require: attempts=1, one CHK pass of 758 cycles, second gen_start with bank_sel=1, done pulse, busy low.
- Retry: first fill has 285 nonzeros, second has 286. Require: attempts=2, two bank-0 gen_starts, then bank-1 run, done.
- Exhaustion: every fill has 300 nonzeros. Require: 8 gen_starts with bank_sel=0, fail pulse, no bank-1 run, attempts=8.
- Stale done: gen_done held high from before start, then drops and rises after 50 cycles. Require: CHK begins only after the new rising edge.
- Reset mid-CHK: assert rst_n=0 at rd_addr=400. Require: all outputs 0 asynchronously, no done/fail; a new start gives a clean run with attempts=1.
- SPOLY_TIMEOUT_EN: generator never asserts gen_done. Require: fail exactly TIMEOUT cycles after gen_start, busy=0. Without the macro, busy stays high.
